// File: rtl/trace_pkg.sv
// Shared types and helpers for the CPU trace capture block.
package trace_pkg;

    localparam int unsigned TRACE_ADDR_W = 16;
    localparam int unsigned TRACE_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3
    } trace_state_t;

    // Entry layout at the default widths; the RAM word uses the same field order.
    typedef struct packed {
        logic                    mem_wr;
        logic [TRACE_DATA_W-1:0] mem_data;
        logic [TRACE_ADDR_W-1:0] mem_addr;
        logic [TRACE_ADDR_W-1:0] pc;
    } trace_entry_t;

    // One comparator: mode 0 matches PC, mode 1 matches a write to mem_addr.
    function automatic logic cmp_hit(input logic en, input logic mode, input logic wr,
                                     input logic pc_eq, input logic addr_eq);
        return en && (mode ? (wr && addr_eq) : pc_eq);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
module trace_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 41,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register is cleared by reset; the array itself is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Triggerable CPU bus trace: circular capture on sample_en, stops post_count
// samples after a comparator hit, random-access readout relative to the oldest entry.
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned NUM_CMP = 2
) (
    input  logic                        Clk,
    input  logic                        reset_n,
    input  logic                        sample_en,
    input  logic [ADDR_W-1:0]           pc,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_data,
    input  logic                        mem_wr,
    input  logic                        arm,
    input  logic                        abort,
    input  logic [NUM_CMP*ADDR_W-1:0]   cmp_val,
    input  logic [NUM_CMP-1:0]          cmp_en,
    input  logic [NUM_CMP-1:0]          cmp_mode,
    input  logic [$clog2(DEPTH)-1:0]    post_count,
    output logic [2:0]                  state,
    output logic                        triggered,
    output logic [$clog2(DEPTH):0]      fill,
    output logic [$clog2(DEPTH)-1:0]    trig_index,
    input  logic [$clog2(DEPTH)-1:0]    rd_addr,
    output logic [2*ADDR_W+DATA_W:0]    rd_data
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned FILL_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2*ADDR_W + DATA_W + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    trace_state_t     state_q,      state_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [FILL_W-1:0] fill_q,      fill_d;
    logic [PTR_W-1:0] trig_ptr_q,   trig_ptr_d;
    logic [PTR_W-1:0] trig_index_q, trig_index_d;
    logic             triggered_q,  triggered_d;
    logic [PTR_W-1:0] post_q,       post_d;
    logic [PTR_W-1:0] remain_q,     remain_d;
    logic             we_c;
    logic             trig_hit_c;
    logic [PTR_W-1:0] rd_phys_c;
    logic             capturing_c;

    // Any enabled comparator matching the current bus sample.
    always_comb begin
        trig_hit_c = 1'b0;
        for (int k = 0; k < int'(NUM_CMP); k++) begin
            trig_hit_c = trig_hit_c | cmp_hit(cmp_en[k], cmp_mode[k], mem_wr,
                                              pc == cmp_val[k*ADDR_W +: ADDR_W],
                                              mem_addr == cmp_val[k*ADDR_W +: ADDR_W]);
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            trig_ptr_q   <= '0;
            trig_index_q <= '0;
            triggered_q  <= 1'b0;
            post_q       <= '0;
            remain_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            trig_ptr_q   <= trig_ptr_d;
            trig_index_q <= trig_index_d;
            triggered_q  <= triggered_d;
            post_q       <= post_d;
            remain_q     <= remain_d;
        end
    end

    // Next state: arm beats abort beats sample; comparators only count in ARMED.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        trig_ptr_d  = trig_ptr_q;
        triggered_d = triggered_q;
        post_d      = post_q;
        remain_d    = remain_q;
        we_c        = 1'b0;
        capturing_c = (state_q == ARMED) || (state_q == POST);

        if (arm) begin
            state_d     = ARMED;
            wr_ptr_d    = '0;
            fill_d      = '0;
            trig_ptr_d  = '0;
            triggered_d = 1'b0;
            post_d      = post_count;
            remain_d    = '0;
        end else if (abort && capturing_c) begin
            state_d = IDLE;
        end else if (sample_en && capturing_c) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
            if (state_q == ARMED) begin
                if (trig_hit_c) begin
                    trig_ptr_d  = wr_ptr_q;
                    triggered_d = 1'b1;
                    if (post_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = POST;
                        remain_d = post_q;
                    end
                end
            end else begin
                remain_d = remain_q - PTR_W'(1);
                if (remain_q == PTR_W'(1)) begin
                    state_d = DONE;
                end
            end
        end

        trig_index_d = trig_ptr_d - (wr_ptr_d - PTR_W'(fill_d));
    end

    // Oldest valid entry sits fill slots behind the write pointer.
    assign rd_phys_c = (wr_ptr_q - PTR_W'(fill_q)) + rd_addr;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (Clk),
        .rst_n   (reset_n),
        .wr_en   (we_c),
        .wr_addr (wr_ptr_q),
        .wr_data ({mem_wr, mem_data, mem_addr, pc}),
        .rd_addr (rd_phys_c),
        .rd_data (rd_data)
    );

    assign state      = state_q;
    assign triggered  = triggered_q;
    assign fill       = fill_q;
    assign trig_index = trig_index_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer at DEPTH=16, NUM_CMP=2.
module tb_cpu_trace_buffer;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned NUM_CMP = 2;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = 2*ADDR_W + DATA_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_POST  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

    logic                      Clk = 1'b0;
    logic                      reset_n;
    logic                      sample_en;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic                      mem_wr;
    logic                      arm;
    logic                      abort;
    logic [NUM_CMP*ADDR_W-1:0] cmp_val;
    logic [NUM_CMP-1:0]        cmp_en;
    logic [NUM_CMP-1:0]        cmp_mode;
    logic [PTR_W-1:0]          post_count;
    logic [2:0]                state;
    logic                      triggered;
    logic [PTR_W:0]            fill;
    logic [PTR_W-1:0]          trig_index;
    logic [PTR_W-1:0]          rd_addr;
    logic [ENTRY_W-1:0]        rd_data;

    int errors = 0;
    int checks = 0;

    cpu_trace_buffer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NUM_CMP (NUM_CMP)
    ) dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .sample_en  (sample_en),
        .pc         (pc),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wr     (mem_wr),
        .arm        (arm),
        .abort      (abort),
        .cmp_val    (cmp_val),
        .cmp_en     (cmp_en),
        .cmp_mode   (cmp_mode),
        .post_count (post_count),
        .state      (state),
        .triggered  (triggered),
        .fill       (fill),
        .trig_index (trig_index),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sampled CPU cycle, inputs held across a single rising edge.
    task automatic do_sample(input logic [15:0] p, input logic [15:0] a,
                             input logic [7:0] d, input logic w);
        @(negedge Clk);
        pc = p; mem_addr = a; mem_data = d; mem_wr = w; sample_en = 1'b1;
        @(negedge Clk);
        sample_en = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge Clk);
        arm = 1'b1;
        @(negedge Clk);
        arm = 1'b0;
    endtask

    task automatic read_entry(input logic [PTR_W-1:0] idx, output logic [ENTRY_W-1:0] e);
        @(negedge Clk);
        rd_addr = idx;
        @(negedge Clk);
        e = rd_data;
    endtask

    logic [ENTRY_W-1:0] ent;

    initial begin
        reset_n = 1'b0; sample_en = 1'b0; pc = '0; mem_addr = '0; mem_data = '0;
        mem_wr = 1'b0; arm = 1'b0; abort = 1'b0; cmp_val = '0; cmp_en = '0;
        cmp_mode = '0; post_count = '0; rd_addr = '0;

        // Reset values
        repeat (2) @(negedge Clk);
        check("rst_state", 64'(state), 64'(S_IDLE));
        check("rst_trig", 64'(triggered), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_tidx", 64'(trig_index), 64'd0);
        check("rst_rdata", 64'(rd_data), 64'd0);
        reset_n = 1'b1;

        // Idle ignores samples
        do_sample(16'h0050, 16'h0000, 8'h00, 1'b0);
        check("idle_fill", 64'(fill), 64'd0);

        // Wrap-around with no trigger
        pulse_arm();
        check("t1_armed", 64'(state), 64'(S_ARMED));
        for (int i = 0; i < 20; i++) begin
            do_sample(16'h0100 + 16'(i), 16'(i), 8'(i), 1'b0);
        end
        check("t1_fill", 64'(fill), 64'd16);
        check("t1_state", 64'(state), 64'(S_ARMED));
        check("t1_trig", 64'(triggered), 64'd0);
        read_entry(4'd0, ent);
        check("t1_rd0", 64'(ent), 64'({1'b0, 8'h04, 16'h0004, 16'h0104}));
        read_entry(4'd15, ent);
        check("t1_rd15_pc", 64'(ent[15:0]), 64'h0113);

        // PC trigger with post_count=3
        cmp_en = 2'b01; cmp_mode = 2'b00; cmp_val = {16'h0000, 16'h0105}; post_count = 4'd3;
        pulse_arm();
        check("t2_fill0", 64'(fill), 64'd0);
        for (int i = 0; i < 16; i++) begin
            do_sample(16'h0100 + 16'(i), 16'h2000, 8'h00, 1'b0);
            if (i == 5) check("t2_post", 64'(state), 64'(S_POST));
            if (i == 7) check("t2_still_post", 64'(state), 64'(S_POST));
        end
        check("t2_done", 64'(state), 64'(S_DONE));
        check("t2_fill", 64'(fill), 64'd9);
        check("t2_trig", 64'(triggered), 64'd1);
        check("t2_tidx", 64'(trig_index), 64'd5);
        read_entry(4'd8, ent);
        check("t2_rd8_pc", 64'(ent[15:0]), 64'h0108);
        read_entry(4'd5, ent);
        check("t2_rd5_pc", 64'(ent[15:0]), 64'h0105);

        // Write-address trigger on comparator 1; reads of the address do not fire
        cmp_en = 2'b10; cmp_mode = 2'b10; cmp_val = {16'hFF40, 16'h0200}; post_count = 4'd0;
        pulse_arm();
        do_sample(16'h0200, 16'hFF40, 8'h55, 1'b0);
        check("t3_read_ign", 64'(state), 64'(S_ARMED));
        do_sample(16'h0201, 16'h1234, 8'h77, 1'b1);
        check("t3_other_wr", 64'(state), 64'(S_ARMED));
        do_sample(16'h0202, 16'hFF40, 8'h91, 1'b1);
        check("t3_done", 64'(state), 64'(S_DONE));
        check("t3_fill", 64'(fill), 64'd3);
        check("t3_tidx", 64'(trig_index), 64'd2);
        read_entry(4'd2, ent);
        check("t3_entry", 64'(ent), 64'({1'b1, 8'h91, 16'hFF40, 16'h0202}));

        // post_count=0, match on third sample; unsampled match ignored
        cmp_en = 2'b01; cmp_mode = 2'b00; cmp_val = {16'h0000, 16'h0302}; post_count = 4'd0;
        pulse_arm();
        @(negedge Clk);
        pc = 16'h0302; mem_wr = 1'b0;
        @(negedge Clk);
        check("t4_nosample", 64'(state), 64'(S_ARMED));
        do_sample(16'h0300, 16'h0000, 8'h00, 1'b0);
        do_sample(16'h0301, 16'h0000, 8'h00, 1'b0);
        check("t4_armed", 64'(state), 64'(S_ARMED));
        do_sample(16'h0302, 16'h0000, 8'h00, 1'b0);
        check("t4_done", 64'(state), 64'(S_DONE));
        check("t4_fill", 64'(fill), 64'd3);
        check("t4_tidx", 64'(trig_index), 64'd2);
        do_sample(16'h0303, 16'h0000, 8'h00, 1'b0);
        check("t4_done_hold", 64'(fill), 64'd3);

        // arm with a matching sample in the same cycle
        cmp_val = {16'h0000, 16'h0400};
        @(negedge Clk);
        arm = 1'b1; sample_en = 1'b1; pc = 16'h0400;
        @(negedge Clk);
        arm = 1'b0; sample_en = 1'b0;
        check("t5_fill", 64'(fill), 64'd0);
        check("t5_trig", 64'(triggered), 64'd0);
        check("t5_state", 64'(state), 64'(S_ARMED));

        // Asynchronous reset while in POST
        cmp_val = {16'h0000, 16'h0500}; post_count = 4'd5;
        pulse_arm();
        do_sample(16'h04FE, 16'h0000, 8'h00, 1'b0);
        do_sample(16'h04FF, 16'h0000, 8'h00, 1'b0);
        do_sample(16'h0500, 16'h0000, 8'h00, 1'b0);
        do_sample(16'h0501, 16'h0000, 8'h00, 1'b0);
        check("t6_post", 64'(state), 64'(S_POST));
        check("t6_fill", 64'(fill), 64'd4);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_state", 64'(state), 64'(S_IDLE));
        check("t6_rst_fill", 64'(fill), 64'd0);
        check("t6_rst_trig", 64'(triggered), 64'd0);
        @(negedge Clk);
        reset_n = 1'b1;

        // Abort in ARMED keeps contents; arm beats abort
        cmp_en = 2'b00; post_count = 4'd0;
        pulse_arm();
        for (int i = 0; i < 5; i++) begin
            do_sample(16'h0600 + 16'(i), 16'h0000, 8'h00, 1'b0);
        end
        @(negedge Clk);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check("t7_idle", 64'(state), 64'(S_IDLE));
        check("t7_fill", 64'(fill), 64'd5);
        do_sample(16'h0700, 16'h0000, 8'h00, 1'b0);
        check("t7_idle_fill", 64'(fill), 64'd5);
        read_entry(4'd4, ent);
        check("t7_rd4_pc", 64'(ent[15:0]), 64'h0604);
        @(negedge Clk);
        arm = 1'b1; abort = 1'b1;
        @(negedge Clk);
        arm = 1'b0; abort = 1'b0;
        check("t8_arm_wins", 64'(state), 64'(S_ARMED));
        check("t8_fill", 64'(fill), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
